// File: rtl/ro_trng_pkg.sv
// Shared constants and types for the ring-oscillator von Neumann extractor.
package ro_trng_pkg;
  localparam int BYTE_W         = 8;
  localparam int REP_W          = 8;
  localparam int REP_LIMIT_DEF  = 32;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic {
    EMPTY      = 1'b0,
    HAVE_FIRST = 1'b1
  } pair_state_t;
endpackage

// File: rtl/ro_byte_fifo.sv
// Small synchronous byte FIFO; the head is read straight from the storage registers.
module ro_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  // a push into a full FIFO is allowed when the head leaves on the same edge
  assign do_push  = push & (~full | pop);
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ro_vn_extractor.sv
// Von Neumann debiaser for a ring-oscillator raw bit stream, with repetition-count
// health monitor and an output byte FIFO.
module ro_vn_extractor
  import ro_trng_pkg::*;
#(
  parameter int REP_LIMIT  = REP_LIMIT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              raw_bit,
  input  logic              raw_valid,
  input  logic              en,
  input  logic              clear,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              health_fail,
  output logic              overflow
);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REP_LIMIT);

  pair_state_t       state_q, state_d;
  logic              first_q;
  logic [BYTE_W-1:0] sreg_q;
  logic [2:0]        cnt_q;
  logic [REP_W-1:0]  rep_q, rep_next;
  logic              last_q;
  logic              armed_q;
  logic              health_q, ovf_q;

  logic accept, vn_valid, byte_done, pop, push, ovf_evt, trip;
  logic fifo_full, fifo_empty;

  // armed_q keeps the first edge after reset release from consuming a sample
  assign accept    = armed_q & en & raw_valid & ~clear;
  assign vn_valid  = accept && (state_q == HAVE_FIRST) && (first_q != raw_bit);
  assign byte_done = vn_valid && (cnt_q == 3'd7) && !health_q;
  assign pop       = out_valid & out_ready;
  assign push      = byte_done && (!fifo_full || pop);
  assign ovf_evt   = byte_done && fifo_full && !pop;
  assign trip      = accept && (rep_next == REP_MAX);

  always_comb begin
    rep_next = REP_W'(1);
    if (rep_q != '0 && raw_bit == last_q)
      rep_next = (rep_q >= REP_MAX) ? REP_MAX : rep_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    if (clear || !en) begin
      state_d = EMPTY;
    end else if (accept) begin
      case (state_q)
        EMPTY:      state_d = HAVE_FIRST;
        HAVE_FIRST: state_d = EMPTY;
        default:    state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      first_q  <= 1'b0;
      sreg_q   <= '0;
      cnt_q    <= '0;
      rep_q    <= '0;
      last_q   <= 1'b0;
      armed_q  <= 1'b0;
      health_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      if (accept && state_q == EMPTY) first_q <= raw_bit;

      if (clear || !en || health_q) begin
        sreg_q <= '0;
        cnt_q  <= '0;
      end else if (vn_valid) begin
        sreg_q <= {sreg_q[BYTE_W-2:0], first_q};
        cnt_q  <= cnt_q + 3'd1;
      end

      if (clear) begin
        rep_q <= '0;
      end else if (accept) begin
        rep_q  <= rep_next;
        last_q <= raw_bit;
      end

      if (clear)     health_q <= 1'b0;
      else if (trip) health_q <= 1'b1;

      if (clear)        ovf_q <= 1'b0;
      else if (ovf_evt) ovf_q <= 1'b1;
    end
  end

  ro_byte_fifo #(.DEPTH(FIFO_DEPTH), .W(BYTE_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({sreg_q[BYTE_W-2:0], first_q}),
    .pop       (pop),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid   = ~fifo_empty;
  assign health_fail = health_q;
  assign overflow    = ovf_q;
endmodule
